prog_mem_loader: RTL

PROG_MEM_LOADER -- requirements
Module: prog_mem_loader

---
 rtl/prog_mem_loader_if.sv | 26 ++
 rtl/prog_mem_loader.sv | 129 ++++++++++++
 2 files changed

// File: rtl/prog_mem_loader_if.sv
// Bundle of the cpu fetch port and the image-load handshake of prog_mem_loader.
// The master modport is the side that fetches and streams the image; the slave modport is the loader.
interface prog_mem_loader_if #(
  parameter int PROG_MEM_SIZE  = 10,
  parameter int PROG_MEM_WIDTH = 8
);
  logic [PROG_MEM_SIZE-1:0]  prog_mem_addr;
  logic [PROG_MEM_WIDTH-1:0] prog_mem_out;
  logic                      load_start;
  logic [PROG_MEM_SIZE:0]    load_len;
  logic [PROG_MEM_WIDTH-1:0] load_data;
  logic                      load_valid;
  logic                      load_ready;
  logic                      cpu_hold;
  logic                      load_done;

  modport master (
    output prog_mem_addr, load_start, load_len, load_data, load_valid,
    input  prog_mem_out, load_ready, cpu_hold, load_done
  );

  modport slave (
    input  prog_mem_addr, load_start, load_len, load_data, load_valid,
    output prog_mem_out, load_ready, cpu_hold, load_done
  );
endinterface

// File: rtl/prog_mem_loader.sv
// Program memory with a synchronous cpu fetch port and a streaming image loader.
// The cpu is held in reset while an image is being written; memory survives reset.
module prog_mem_loader #(
  parameter int PROG_MEM_SIZE  = 10,
  parameter int PROG_MEM_WIDTH = 8
) (
  input logic               clk,
  input logic               reset,
  prog_mem_loader_if.slave  bus
);

  localparam int                     DEPTH     = 1 << PROG_MEM_SIZE;
  localparam logic [PROG_MEM_SIZE:0] LEN_DEPTH = (PROG_MEM_SIZE + 1)'(DEPTH);
  localparam logic [PROG_MEM_SIZE:0] LEN_ZERO  = {(PROG_MEM_SIZE + 1){1'b0}};
  localparam logic [PROG_MEM_SIZE:0] LEN_ONE   = {{PROG_MEM_SIZE{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                    state_r;
  state_t                    next_state_s;
  logic [PROG_MEM_SIZE:0]    ptr_r;
  logic [PROG_MEM_SIZE:0]    len_r;
  logic [PROG_MEM_SIZE:0]    ptr_next_s;
  logic [PROG_MEM_WIDTH-1:0] mem_r [DEPTH];
  logic [PROG_MEM_WIDTH-1:0] rd_data_r;
  logic                      cpu_hold_r;
  logic                      load_ready_r;
  logic                      load_done_r;
  logic                      accept_s;
  logic                      last_s;
  logic                      begin_load_s;

  // Oversized images are clamped so the pointer can never wrap onto bytes already written.
  function automatic logic [PROG_MEM_SIZE:0] clamp_len(input logic [PROG_MEM_SIZE:0] len_in);
    if (len_in > LEN_DEPTH) begin
      return LEN_DEPTH;
    end else begin
      return len_in;
    end
  endfunction

  assign accept_s     = (state_r == LOAD) && load_ready_r && bus.load_valid;
  assign ptr_next_s   = ptr_r + LEN_ONE;
  assign last_s       = (ptr_next_s == len_r);
  assign begin_load_s = (state_r == IDLE) && bus.load_start && (bus.load_len != LEN_ZERO);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.load_start) begin
          if (bus.load_len == LEN_ZERO) begin
            next_state_s = DONE;
          end else begin
            next_state_s = LOAD;
          end
        end else begin
          next_state_s = IDLE;
        end
      end
      LOAD: begin
        if (accept_s && last_s) begin
          next_state_s = DONE;
        end else begin
          next_state_s = LOAD;
        end
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Pointer, length and registered handshake outputs derived from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_r        <= LEN_ZERO;
      len_r        <= LEN_ZERO;
      load_ready_r <= 1'b0;
      load_done_r  <= 1'b0;
      cpu_hold_r   <= 1'b1;
    end else begin
      load_ready_r <= (next_state_s == LOAD);
      load_done_r  <= (next_state_s == DONE);
      cpu_hold_r   <= (next_state_s != IDLE);
      if (begin_load_s) begin
        ptr_r <= LEN_ZERO;
        len_r <= clamp_len(bus.load_len);
      end else if (accept_s) begin
        ptr_r <= ptr_next_s;
      end
    end
  end

  // Image write port; memory contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (accept_s && !reset) begin
      mem_r[ptr_r[PROG_MEM_SIZE-1:0]] <= bus.load_data;
    end
  end

  // Fetch port: one-cycle read that sees the pre-write contents on a same-address collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_r <= {PROG_MEM_WIDTH{1'b0}};
    end else begin
      rd_data_r <= mem_r[bus.prog_mem_addr];
    end
  end

  assign bus.prog_mem_out = rd_data_r;
  assign bus.load_ready   = load_ready_r;
  assign bus.load_done    = load_done_r;
  assign bus.cpu_hold     = cpu_hold_r;

endmodule
